// File: rtl/ysyx_23060240_mem_arb.sv
// ysyx_23060240_mem_arb
// Shares the single memory port between the instruction fetch unit (IFU) and the
// load/store unit (LSU). Only one transaction is in flight at a time. The LSU always
// wins over the IFU. The granted request is latched and presented to memory, and the
// response is routed back to the master that owns the transaction.
// Reset is synchronous and active-low (rst == 0 at a rising clock edge).
// Optional feature macro: ARB_TIMEOUT_EN adds a watchdog. When the watchdog expires,
// the owner receives an error response with zero data.
module ysyx_23060240_mem_arb #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_rsp_valid,
    output logic [DATA_W-1:0]   ifu_rsp_data,
    output logic                ifu_rsp_err,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_rsp_valid,
    output logic [DATA_W-1:0]   lsu_rsp_data,
    output logic                lsu_rsp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IFU  = 2'd1,
        OWN_LSU  = 2'd2
    } owner_t;

    state_t                r_state;
    state_t                w_state_next;
    owner_t                r_owner;
    logic [ADDR_W-1:0]     r_addr;
    logic                  r_wen;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W/8-1:0]   r_wmask;

    logic                  w_lsu_acc;
    logic                  w_ifu_acc;
    logic                  w_rsp_fire;
    logic                  w_timeout;
    logic                  w_done;

    // Accept decisions. The LSU has absolute priority. The IFU is granted only when
    // the LSU is silent.
    assign w_lsu_acc  = (r_state == S_IDLE) && lsu_req_valid;
    assign w_ifu_acc  = (r_state == S_IDLE) && !lsu_req_valid && ifu_req_valid;
    assign w_rsp_fire = (r_state == S_RESP) && mem_rsp_valid;

`ifdef ARB_TIMEOUT_EN
    localparam int WDOG_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [WDOG_W-1:0] r_wdog;

    // The watchdog is zeroed when a request is accepted, so it starts at zero in the
    // first REQ cycle. It then counts every cycle spent in REQ/RESP.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wdog <= '0;
        end else if (w_lsu_acc || w_ifu_acc) begin
            r_wdog <= '0;
        end else if (r_state != S_IDLE) begin
            r_wdog <= r_wdog + 1'b1;
        end
    end

    // The timeout fires on the TIMEOUT_CYCLES-th waiting cycle. A real response in the
    // same cycle takes precedence.
    assign w_timeout = (r_state != S_IDLE)
                     && (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1))
                     && !w_rsp_fire;
`else
    logic w_unused;

    assign w_unused  = (TIMEOUT_CYCLES != 0);
    assign w_timeout = 1'b0;
`endif

    // State register. Reset drops any transaction in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic for IDLE -> REQ -> RESP -> IDLE, with the watchdog as an early exit.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_lsu_acc || w_ifu_acc) begin
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (w_timeout) begin
                    w_state_next = S_IDLE;
                end else if (mem_req_ready) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (w_rsp_fire || w_timeout) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Latch the granted request and its owner. The fields stay stable until the next grant.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_owner <= OWN_NONE;
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_wmask <= '0;
        end else if (w_lsu_acc) begin
            r_owner <= OWN_LSU;
            r_addr  <= lsu_addr;
            r_wen   <= lsu_wen;
            r_wdata <= lsu_wdata;
            r_wmask <= lsu_wmask;
        end else if (w_ifu_acc) begin
            r_owner <= OWN_IFU;
            r_addr  <= ifu_addr;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_wmask <= '0;
        end else if ((r_state != S_IDLE) && (w_state_next == S_IDLE)) begin
            r_owner <= OWN_NONE;
        end
    end

    // Master-facing handshakes and response routing. Every output is held quiet while
    // reset is asserted.
    always_comb begin
        w_done        = rst && (w_rsp_fire || w_timeout);
        ifu_req_ready = rst && w_ifu_acc;
        lsu_req_ready = rst && w_lsu_acc;
        ifu_rsp_valid = 1'b0;
        ifu_rsp_data  = '0;
        ifu_rsp_err   = 1'b0;
        lsu_rsp_valid = 1'b0;
        lsu_rsp_data  = '0;
        lsu_rsp_err   = 1'b0;
        if (w_done && (r_owner == OWN_IFU)) begin
            ifu_rsp_valid = 1'b1;
            ifu_rsp_err   = w_timeout;
            ifu_rsp_data  = w_rsp_fire ? mem_rsp_data : '0;
        end
        if (w_done && (r_owner == OWN_LSU)) begin
            lsu_rsp_valid = 1'b1;
            lsu_rsp_err   = w_timeout;
            lsu_rsp_data  = (w_rsp_fire && !r_wen) ? mem_rsp_data : '0;
        end
    end

    assign mem_req_valid = (r_state == S_REQ);
    assign mem_addr      = r_addr;
    assign mem_wen       = r_wen;
    assign mem_wdata     = r_wdata;
    assign mem_wmask     = r_wmask;

endmodule

// File: tb/tb_ysyx_23060240_mem_arb.sv
// Directed testbench for ysyx_23060240_mem_arb.
// Inputs are driven on the falling edge. Outputs are sampled 1 ns later, so every
// comparison sits between two rising edges.
module tb_ysyx_23060240_mem_arb;

    logic        clk;
    logic        rst;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rsp_data;
    logic        ifu_rsp_err;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        lsu_rsp_valid;
    logic [31:0] lsu_rsp_data;
    logic        lsu_rsp_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;

    int total;
    int bad;

    ysyx_23060240_mem_arb #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ifu_req_valid(ifu_req_valid),
        .ifu_req_ready(ifu_req_ready),
        .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid),
        .ifu_rsp_data(ifu_rsp_data),
        .ifu_rsp_err(ifu_rsp_err),
        .lsu_req_valid(lsu_req_valid),
        .lsu_req_ready(lsu_req_ready),
        .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen),
        .lsu_wdata(lsu_wdata),
        .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(lsu_rsp_valid),
        .lsu_rsp_data(lsu_rsp_data),
        .lsu_rsp_err(lsu_rsp_err),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr),
        .mem_wen(mem_wen),
        .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus();
        @(negedge clk);
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst           = 1'b0;
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0000;
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_1000;
        lsu_wen       = 1'b1;
        lsu_wdata     = 32'hDEAD_BEEF;
        lsu_wmask     = 4'hF;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h1234_5678;

        // Reset with both masters requesting: nothing may be granted or emitted
        repeat (3) @(posedge clk);
        applyStimulus(); #1;
        checkOutput("rst_ifu_ready", 32'(ifu_req_ready), 32'd0);
        checkOutput("rst_lsu_ready", 32'(lsu_req_ready), 32'd0);
        checkOutput("rst_mem_valid", 32'(mem_req_valid), 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_mem_wen", 32'(mem_wen), 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        checkOutput("rst_mem_wmask", 32'(mem_wmask), 32'd0);
        checkOutput("rst_ifu_rsp", 32'(ifu_rsp_valid), 32'd0);
        checkOutput("rst_lsu_rsp", 32'(lsu_rsp_valid), 32'd0);
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        mem_rsp_valid = 1'b0;

        // Basic IFU fetch: accept at cycle 0, response at cycle 2
        $display("[TB] IFU fetch");
        applyStimulus();
        rst           = 1'b1;
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0000;
        mem_req_ready = 1'b1;
        #1;
        checkOutput("f1_ifu_ready", 32'(ifu_req_ready), 32'd1);
        checkOutput("f1_lsu_ready", 32'(lsu_req_ready), 32'd0);
        applyStimulus();
        ifu_req_valid = 1'b0;
        #1;
        checkOutput("f1_mem_valid", 32'(mem_req_valid), 32'd1);
        checkOutput("f1_mem_addr", mem_addr, 32'h8000_0000);
        checkOutput("f1_mem_wen", 32'(mem_wen), 32'd0);
        checkOutput("f1_mem_wmask", 32'(mem_wmask), 32'd0);
        checkOutput("f1_ready_busy", 32'(ifu_req_ready), 32'd0);
        applyStimulus();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0000_0413;
        #1;
        checkOutput("f1_rsp_valid", 32'(ifu_rsp_valid), 32'd1);
        checkOutput("f1_rsp_data", ifu_rsp_data, 32'h0000_0413);
        checkOutput("f1_rsp_err", 32'(ifu_rsp_err), 32'd0);
        checkOutput("f1_lsu_rsp", 32'(lsu_rsp_valid), 32'd0);
        checkOutput("f1_mem_valid_resp", 32'(mem_req_valid), 32'd0);
        applyStimulus();
        mem_rsp_valid = 1'b0;
        #1;
        checkOutput("f1_rsp_pulse_end", 32'(ifu_rsp_valid), 32'd0);

        // Simultaneous requests: the LSU store wins, and the IFU is granted at cycle 3
        $display("[TB] LSU priority");
        applyStimulus();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0004;
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_1000;
        lsu_wen       = 1'b1;
        lsu_wdata     = 32'hDEAD_BEEF;
        lsu_wmask     = 4'hF;
        mem_req_ready = 1'b1;
        #1;
        checkOutput("p_lsu_ready", 32'(lsu_req_ready), 32'd1);
        checkOutput("p_ifu_ready", 32'(ifu_req_ready), 32'd0);
        applyStimulus();
        lsu_req_valid = 1'b0;
        #1;
        checkOutput("p_mem_wen", 32'(mem_wen), 32'd1);
        checkOutput("p_mem_addr", mem_addr, 32'h8000_1000);
        checkOutput("p_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        checkOutput("p_mem_wmask", 32'(mem_wmask), 32'hF);
        checkOutput("p_ifu_ready_req", 32'(ifu_req_ready), 32'd0);
        applyStimulus();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hCAFE_F00D;
        #1;
        checkOutput("p_lsu_rsp", 32'(lsu_rsp_valid), 32'd1);
        checkOutput("p_store_data", lsu_rsp_data, 32'd0);
        checkOutput("p_ifu_rsp", 32'(ifu_rsp_valid), 32'd0);
        checkOutput("p_ifu_ready_resp", 32'(ifu_req_ready), 32'd0);
        applyStimulus();
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        checkOutput("p_ifu_ready_c3", 32'(ifu_req_ready), 32'd1);
        applyStimulus();
        ifu_req_valid = 1'b0;
        #1;
        checkOutput("p_ifu_addr", mem_addr, 32'h8000_0004);
        checkOutput("p_ifu_wen", 32'(mem_wen), 32'd0);
        checkOutput("p_ifu_wmask", 32'(mem_wmask), 32'd0);
        applyStimulus();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0010_0073;
        #1;
        checkOutput("p_ifu_rsp_valid", 32'(ifu_rsp_valid), 32'd1);
        checkOutput("p_ifu_rsp_data", ifu_rsp_data, 32'h0010_0073);
        checkOutput("p_lsu_rsp_quiet", 32'(lsu_rsp_valid), 32'd0);
        applyStimulus();
        mem_rsp_valid = 1'b0;

        // LSU load stalled in REQ for 5 cycles; a stray mem_rsp_valid there must be ignored
        $display("[TB] REQ stall and LSU load");
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_2000;
        lsu_wen       = 1'b0;
        lsu_wdata     = 32'h1111_1111;
        lsu_wmask     = 4'h3;
        mem_req_ready = 1'b0;
        #1;
        checkOutput("s_lsu_ready", 32'(lsu_req_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            lsu_req_valid = 1'b0;
            lsu_addr      = 32'h0;
            lsu_wdata     = 32'h0;
            lsu_wmask     = 4'h0;
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = 32'hBAD0_BAD0;
            #1;
            checkOutput("s_mem_valid", 32'(mem_req_valid), 32'd1);
            checkOutput("s_mem_addr", mem_addr, 32'h8000_2000);
            checkOutput("s_mem_wdata", mem_wdata, 32'h1111_1111);
            checkOutput("s_mem_wmask", 32'(mem_wmask), 32'h3);
            checkOutput("s_lsu_rsp", 32'(lsu_rsp_valid), 32'd0);
            checkOutput("s_ifu_rsp", 32'(ifu_rsp_valid), 32'd0);
        end
        applyStimulus();
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        checkOutput("s_mem_valid_go", 32'(mem_req_valid), 32'd1);
        applyStimulus();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h1234_5678;
        #1;
        checkOutput("s_load_valid", 32'(lsu_rsp_valid), 32'd1);
        checkOutput("s_load_data", lsu_rsp_data, 32'h1234_5678);
        checkOutput("s_load_err", 32'(lsu_rsp_err), 32'd0);
        checkOutput("s_load_ifu_quiet", 32'(ifu_rsp_valid), 32'd0);
        applyStimulus();
        mem_rsp_valid = 1'b0;

        // Reset while in RESP, then a late response: nothing may reach either master
        $display("[TB] reset in RESP");
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0008;
        mem_req_ready = 1'b1;
        applyStimulus();
        ifu_req_valid = 1'b0;
        applyStimulus();
        mem_req_ready = 1'b0;
        rst           = 1'b0;
        #1;
        checkOutput("r_ifu_rsp_rst", 32'(ifu_rsp_valid), 32'd0);
        applyStimulus();
        rst           = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0000_0055;
        #1;
        checkOutput("r_late_ifu", 32'(ifu_rsp_valid), 32'd0);
        checkOutput("r_late_lsu", 32'(lsu_rsp_valid), 32'd0);
        checkOutput("r_mem_valid", 32'(mem_req_valid), 32'd0);
        applyStimulus();
        mem_rsp_valid = 1'b0;
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_000C;
        mem_req_ready = 1'b1;
        #1;
        checkOutput("r_idle_accept", 32'(ifu_req_ready), 32'd1);
        applyStimulus();
        ifu_req_valid = 1'b0;
        #1;
        checkOutput("r_mem_addr", mem_addr, 32'h8000_000C);
        applyStimulus();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0000_0013;
        #1;
        checkOutput("r_rsp_data", ifu_rsp_data, 32'h0000_0013);
        checkOutput("r_rsp_valid", 32'(ifu_rsp_valid), 32'd1);
        applyStimulus();
        mem_rsp_valid = 1'b0;

`ifdef ARB_TIMEOUT_EN
        // Memory never responds: an error response arrives on the 16th waiting cycle
        $display("[TB] watchdog timeout");
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_3000;
        lsu_wen       = 1'b0;
        mem_req_ready = 1'b0;
        #1;
        checkOutput("t_lsu_ready", 32'(lsu_req_ready), 32'd1);
        for (int k = 1; k < 16; k++) begin
            applyStimulus();
            lsu_req_valid = 1'b0;
            #1;
            checkOutput("t_wait_quiet", 32'(lsu_rsp_valid), 32'd0);
        end
        applyStimulus(); #1;
        checkOutput("t_rsp_valid", 32'(lsu_rsp_valid), 32'd1);
        checkOutput("t_rsp_err", 32'(lsu_rsp_err), 32'd1);
        checkOutput("t_rsp_data", lsu_rsp_data, 32'd0);
        applyStimulus();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0010;
        #1;
        checkOutput("t_next_accept", 32'(ifu_req_ready), 32'd1);
        applyStimulus();
        ifu_req_valid = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
